clint_timer: RTL and testbench
==============================

Name: clint_timer

Overview:
- Machine-level interrupt source for the core: owns mtime, mtimecmp and msip.
- Drives timer_interrupt and software_interrupt into the CSR/trap logic.
- Memory-mapped behind a single-outstanding valid/ready request/response port driven by the load/store path.
- Sole producer of the timer and software interrupt lines the core samples.

Parameters:
- TICK_DIV, 1: clk cycles per mtime increment; legal range 1..65535.
- ADDR_W, 16: request address width (byte address, offset within block).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- tick_enable  in  1  mtime advances only while high (debug halt freezes time)
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  write data, full-word only
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_rdata  out  32  read data; 0 for writes and errors
- resp_error  out  1  unmapped or misaligned access
- timer_interrupt  out  1  mtime >= mtimecmp (unsigned 64-bit), registered
- software_interrupt  out  1  msip bit 0

Behaviour:
- Register map (word-aligned):
  - 0x0000 MSIP: bit0 is R/W; bits 31:1 read 0 and ignore writes.
  - 0x4000 MTIMECMP[31:0], 0x4004 MTIMECMP[63:32].
  - 0xBFF8 MTIME[31:0], 0xBFFC MTIME[63:32].
- Error conditions: any other address, or req_addr[1:0] != 0, gives resp_error=1 and resp_rdata=0; no state change.
- Reset (reset low, async):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0.
  - resp_valid=0, resp_rdata=0, resp_error=0, timer_interrupt=0, software_interrupt=0.
  - Reset mid-transaction drops any pending response.
- Handshake:
  - req_ready = !resp_valid || resp_ready (combinational); one transaction outstanding at most.
  - Accepted request produces resp_valid on the next cycle.
  - resp_valid, resp_rdata and resp_error hold stable until resp_ready.
  - Back-to-back accepted requests with resp_ready held high give one response per cycle.
- Write effects: register updates at the accept edge. Read data reflects register values at the accept edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 while tick_enable=1 and holds while tick_enable=0.
  - At terminal count, wraps to 0 and mtime increments by 1.
  - TICK_DIV=1: mtime increments every enabled cycle.
- mtime wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0.
- Write to MTIME (either half) on a tick cycle: written half takes the write data, other half holds, the increment is suppressed for that cycle, and the prescaler continues unaffected.
- No carry is applied between halves on a software write.
- timer_interrupt:
  - Registered each cycle from the current mtime/mtimecmp registers, so it lags any register change by one cycle.
  - Level, not pulse: stays high until mtimecmp is raised above mtime or mtime wraps.
- software_interrupt = msip register; visible the cycle after the write.
- Reads of MTIME are not atomic across halves; software uses the hi/lo/hi loop.

Test Plan:
- Reset, then idle 10 cycles with tick_enable=1, TICK_DIV=1 -> timer_interrupt=0, and read 0xBFF8 returns 0x0000000A ±1 depending on the read-accept cycle; checker computes the exact value.
- Write MTIMECMP lo=0x20, hi=0 while mtime=0x10 -> timer_interrupt rises exactly one cycle after mtime reaches 0x20. Then write MTIMECMP lo=0xFFFF_FFFF -> timer_interrupt falls one cycle after the accept.
- TICK_DIV=4, tick_enable toggled low for 3 cycles mid-count -> mtime increments only after 4 enabled cycles; with tick_enable=0 throughout, the value is frozen.
- Write MTIME hi=0xFFFF_FFFF, lo=0xFFFF_FFFF, then run 2 ticks -> mtime wraps to 0x1, and the lo write on a tick cycle shows no increment.
- Write MSIP=0xFFFF_FFFF -> software_interrupt=1 next cycle and read returns 0x1. Write MSIP=0 -> software_interrupt=0.
- Read 0x0008, then read 0x4002, with resp_ready held low 3 cycles -> resp_error=1 and resp_rdata=0 for both, resp_valid held stable, req_ready=0 until the response is consumed, and no register changes.

Source files
------------

// File: rtl/clint_timer.sv
// clint_timer: machine-level timer/software interrupt block.
// Owns mtime, mtimecmp and msip behind a single-outstanding valid/ready
// request/response port.
//
// Ports:
//   clk, reset (async, active low)
//   tick_enable        : mtime advances only while high
//   req_valid/ready    : request handshake (req_write, req_addr, req_wdata)
//   resp_valid/ready   : response handshake (resp_rdata, resp_error)
//   timer_interrupt    : registered mtime >= mtimecmp (unsigned 64-bit)
//   software_interrupt : msip bit 0
//
// Register map (word aligned):
//   0x0000 MSIP, 0x4000/0x4004 MTIMECMP lo/hi, 0xBFF8/0xBFFC MTIME lo/hi
module clint_timer #(
  parameter int TICK_DIV = 1,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_enable,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              timer_interrupt,
  output logic              software_interrupt
);

  localparam logic [ADDR_W-1:0] A_MSIP   = ADDR_W'(16'h0000);
  localparam logic [ADDR_W-1:0] A_CMP_LO = ADDR_W'(16'h4000);
  localparam logic [ADDR_W-1:0] A_CMP_HI = ADDR_W'(16'h4004);
  localparam logic [ADDR_W-1:0] A_MT_LO  = ADDR_W'(16'hBFF8);
  localparam logic [ADDR_W-1:0] A_MT_HI  = ADDR_W'(16'hBFFC);
  localparam logic [15:0]       TERM     = 16'(TICK_DIV - 1);

  typedef struct packed {
    logic        valid;
    logic        error;
    logic [31:0] rdata;
  } resp_t;

  logic [63:0] mtime, mtimecmp;
  logic        msip;
  logic [15:0] presc;
  resp_t       resp_q;

  logic        accept, tick, hit, wr;
  logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
  logic [31:0] rd_mux;

  assign req_ready = !resp_q.valid || resp_ready;
  assign accept    = req_valid && req_ready;
  assign tick      = tick_enable && (presc == TERM);

  // Misaligned addresses never match a register, so they fall out as errors.
  always_comb begin
    sel_msip   = (req_addr == A_MSIP);
    sel_cmp_lo = (req_addr == A_CMP_LO);
    sel_cmp_hi = (req_addr == A_CMP_HI);
    sel_mt_lo  = (req_addr == A_MT_LO);
    sel_mt_hi  = (req_addr == A_MT_HI);
    hit        = (req_addr[1:0] == 2'b00) &&
                 (sel_msip || sel_cmp_lo || sel_cmp_hi || sel_mt_lo || sel_mt_hi);
    wr         = accept && req_write && hit;
    rd_mux     = '0;
    if (sel_msip)   rd_mux = {31'b0, msip};
    if (sel_cmp_lo) rd_mux = mtimecmp[31:0];
    if (sel_cmp_hi) rd_mux = mtimecmp[63:32];
    if (sel_mt_lo)  rd_mux = mtime[31:0];
    if (sel_mt_hi)  rd_mux = mtime[63:32];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else begin
      if (tick_enable) presc <= tick ? 16'd0 : presc + 16'd1;
      // A software write to either half wins over the tick; the other half
      // holds and no carry crosses halves.
      if (wr && sel_mt_lo)      mtime[31:0]  <= req_wdata;
      else if (wr && sel_mt_hi) mtime[63:32] <= req_wdata;
      else if (tick)            mtime        <= mtime + 64'd1;
      if (wr && sel_cmp_lo) mtimecmp[31:0]  <= req_wdata;
      if (wr && sel_cmp_hi) mtimecmp[63:32] <= req_wdata;
      if (wr && sel_msip)   msip            <= req_wdata[0];
    end
  end

  // Compare uses pre-update registers, so the interrupt lags writes by a cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timer_interrupt <= 1'b0;
    else        timer_interrupt <= (mtime >= mtimecmp);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_q <= '0;
    end else if (accept) begin
      resp_q.valid <= 1'b1;
      resp_q.error <= !hit;
      resp_q.rdata <= (!req_write && hit) ? rd_mux : 32'd0;
    end else if (resp_ready) begin
      resp_q.valid <= 1'b0;
    end
  end

  assign resp_valid         = resp_q.valid;
  assign resp_error         = resp_q.error;
  assign resp_rdata         = resp_q.rdata;
  assign software_interrupt = msip;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: dut0 runs TICK_DIV=1, dut1 runs TICK_DIV=4.
// Expected responses go into a scoreboard queue when a request is driven and
// are popped and compared when the response arrives.
module tb_clint_timer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  tick_enable, req_valid, req_ready, req_write;
  logic [1:0]  resp_valid, resp_ready, resp_error, timer_interrupt, software_interrupt;
  logic [15:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] resp_rdata [2];

  clint_timer #(.TICK_DIV(1), .ADDR_W(16)) dut0 (
    .clk(clk), .reset(reset), .tick_enable(tick_enable[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]),
    .timer_interrupt(timer_interrupt[0]), .software_interrupt(software_interrupt[0]));

  clint_timer #(.TICK_DIV(4), .ADDR_W(16)) dut1 (
    .clk(clk), .reset(reset), .tick_enable(tick_enable[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]),
    .timer_interrupt(timer_interrupt[1]), .software_interrupt(software_interrupt[1]));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // Reference count of enabled edges on dut0 since reset release.
  logic [63:0] en_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) en_cnt <= '0;
    else if (tick_enable[0]) en_cnt <= en_cnt + 64'd1;
  end

  // One request with resp_ready high; call just after a negedge, returns at
  // the negedge where the response is visible.
  task automatic xact(input int i, input logic w, input logic [15:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic er);
    int n;
    req_valid[i] = 1'b1; req_write[i] = w; req_addr[i] = a; req_wdata[i] = d;
    resp_ready[i] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[i] && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
    n = 0;
    while (!resp_valid[i] && n < 20) begin @(negedge clk); n++; end
    rd = resp_rdata[i];
    er = resp_error[i];
    checks++;
    if (resp_valid[i] !== 1'b1) begin
      failures++;
      $display("FAIL xact_timeout addr=%h resp_valid=%b required=1", a, resp_valid[i]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick_enable = '0; req_valid = '0; req_write = '0; resp_ready = '1;
    for (int i = 0; i < 2; i++) begin req_addr[i] = '0; req_wdata[i] = '0; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({resp_valid[i], resp_error[i], timer_interrupt[i], software_interrupt[i],
           req_ready[i]} !== 5'b00001 || resp_rdata[i] !== 32'd0) begin
        failures++;
        $display("FAIL reset_state dut%0d got v/e/ti/sw/rdy=%b%b%b%b%b rdata=%h required 00001/0",
                 i, resp_valid[i], resp_error[i], timer_interrupt[i],
                 software_interrupt[i], req_ready[i], resp_rdata[i]);
      end
    end
    reset = 1'b1;
    tick_enable[0] = 1'b1;
  endtask

  task automatic test_idle_read();
    logic [31:0] rd; logic er; exp_t e;
    repeat (10) @(negedge clk);
    checks++;
    if (timer_interrupt[0] !== 1'b0) begin
      failures++;
      $display("FAIL idle_ti got=%b required=0", timer_interrupt[0]);
    end
    sb.push_back('{rdata: en_cnt[31:0], err: 1'b0});
    xact(0, 1'b0, 16'hBFF8, 32'd0, rd, er);
    e = sb.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin
      failures++;
      $display("FAIL idle_mtime got=%h/%b required=%h/%b", rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_timer_cmp();
    logic [31:0] rd; logic er; exp_t e; logic expi;
    while (en_cnt < 64'd14) @(negedge clk);
    sb.push_back('{rdata: 32'd0, err: 1'b0});
    xact(0, 1'b1, 16'h4000, 32'h20, rd, er);
    sb.push_back('{rdata: 32'd0, err: 1'b0});
    xact(0, 1'b1, 16'h4004, 32'h0, rd, er);
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      checks++;
      if (rd !== e.rdata || er !== e.err) begin
        failures++;
        $display("FAIL cmp_write got=%h/%b required=%h/%b", rd, er, e.rdata, e.err);
      end
    end
    @(negedge clk);
    // Interrupt reflects mtime as it stood before the last edge.
    while (en_cnt < 64'h24) begin
      expi = ((en_cnt - 64'd1) >= 64'h20);
      checks++;
      if (timer_interrupt[0] !== expi) begin
        failures++;
        $display("FAIL ti_rise mtime=%h got=%b required=%b", en_cnt, timer_interrupt[0], expi);
      end
      @(negedge clk);
    end
    sb.push_back('{rdata: 32'd0, err: 1'b0});
    xact(0, 1'b1, 16'h4000, 32'hFFFF_FFFF, rd, er);
    e = sb.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err || timer_interrupt[0] !== 1'b1) begin
      failures++;
      $display("FAIL ti_hold_at_accept got=%h/%b ti=%b required=%h/%b ti=1",
               rd, er, timer_interrupt[0], e.rdata, e.err);
    end
    @(negedge clk);
    checks++;
    if (timer_interrupt[0] !== 1'b0) begin
      failures++;
      $display("FAIL ti_fall got=%b required=0", timer_interrupt[0]);
    end
  endtask

  task automatic test_prescaler();
    logic [31:0] rd; logic er; exp_t e;
    logic [31:0] want [4] = '{32'd0, 32'd0, 32'd0, 32'd1};
    // Step 0: frozen since reset. Steps 1..3 add 2, 1, 1 enabled edges.
    for (int s = 0; s < 4; s++) begin
      if (s == 1) begin
        tick_enable[1] = 1'b1; repeat (2) @(negedge clk);
        tick_enable[1] = 1'b0; repeat (3) @(negedge clk);
      end else if (s >= 2) begin
        tick_enable[1] = 1'b1; @(negedge clk); tick_enable[1] = 1'b0;
      end
      sb.push_back('{rdata: want[s], err: 1'b0});
      xact(1, 1'b0, 16'hBFF8, 32'd0, rd, er);
      e = sb.pop_front();
      checks++;
      if (rd !== e.rdata || er !== e.err) begin
        failures++;
        $display("FAIL presc_step%0d got=%h/%b required=%h/%b", s, rd, er, e.rdata, e.err);
      end
    end
    tick_enable[1] = 1'b1; repeat (8) @(negedge clk); tick_enable[1] = 1'b0;
    sb.push_back('{rdata: 32'd3, err: 1'b0});
    xact(1, 1'b0, 16'hBFF8, 32'd0, rd, er);
    e = sb.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin
      failures++;
      $display("FAIL presc_8cyc got=%h/%b required=%h/%b", rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; exp_t e;
    logic        w    [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] a    [7] = '{16'hBFFC, 16'hBFF8, 16'hBFF8, 16'hBFF8, 16'hBFF8, 16'hBFF8, 16'hBFFC};
    logic [31:0] d    [7] = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] want [7];
    // lo is unchanged by the hi write's tick edge, then all-ones, wrap, count.
    want = '{32'd0, en_cnt[31:0], 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0};
    for (int k = 0; k < 7; k++) begin
      sb.push_back('{rdata: want[k], err: 1'b0});
      xact(0, w[k], a[k], d[k], rd, er);
      e = sb.pop_front();
      checks++;
      if (rd !== e.rdata || er !== e.err) begin
        failures++;
        $display("FAIL wrap_step%0d got=%h/%b required=%h/%b", k, rd, er, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_msip();
    logic [31:0] rd; logic er; exp_t e;
    logic [31:0] d    [4] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    logic        w    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] want [4] = '{32'd0, 32'd1, 32'd0, 32'd0};
    logic        sw   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    checks++;
    if (software_interrupt[0] !== 1'b0) begin
      failures++;
      $display("FAIL msip_initial got=%b required=0", software_interrupt[0]);
    end
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{rdata: want[k], err: 1'b0});
      xact(0, w[k], 16'h0000, d[k], rd, er);
      e = sb.pop_front();
      checks++;
      if (rd !== e.rdata || er !== e.err || software_interrupt[0] !== sw[k]) begin
        failures++;
        $display("FAIL msip_step%0d got=%h/%b sw=%b required=%h/%b sw=%b",
                 k, rd, er, software_interrupt[0], e.rdata, e.err, sw[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] a    [3] = '{16'h0000, 16'h4000, 16'h4004};
    logic [31:0] want [3] = '{32'd0, 32'hFFFF_FFFF, 32'd0};
    resp_ready[0] = 1'b1; req_write[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[0] = 1'b1; req_addr[0] = a[k];
      sb.push_back('{rdata: want[k], err: 1'b0});
      #1;
      checks++;
      if (req_ready[0] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready%0d got=%b required=1", k, req_ready[0]);
      end
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== e.rdata || resp_error[0] !== e.err) begin
        failures++;
        $display("FAIL b2b_resp%0d got=%b/%h/%b required=1/%h/%b",
                 k, resp_valid[0], resp_rdata[0], resp_error[0], e.rdata, e.err);
      end
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_error();
    logic [31:0] rd; logic er; exp_t e;
    logic [15:0] a [2] = '{16'h0008, 16'h4002};
    for (int k = 0; k < 2; k++) begin
      req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = a[k];
      resp_ready[0] = 1'b0;
      sb.push_back('{rdata: 32'd0, err: 1'b1});
      #1;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      e = sb.pop_front();
      for (int j = 0; j < 3; j++) begin
        checks++;
        if ({resp_valid[0], req_ready[0]} !== 2'b10 || resp_rdata[0] !== e.rdata ||
            resp_error[0] !== e.err) begin
          failures++;
          $display("FAIL err_hold a=%h cyc%0d got v/rdy=%b%b %h/%b required 10 %h/%b",
                   a[k], j, resp_valid[0], req_ready[0], resp_rdata[0], resp_error[0],
                   e.rdata, e.err);
        end
        @(negedge clk);
      end
      resp_ready[0] = 1'b1;
      #1;
      checks++;
      if (req_ready[0] !== 1'b1) begin
        failures++;
        $display("FAIL err_release got=%b required=1", req_ready[0]);
      end
      @(negedge clk);
    end
    // Erroring writes must not disturb state.
    sb.push_back('{rdata: 32'd0, err: 1'b1});
    xact(0, 1'b1, 16'h4002, 32'h1234_5678, rd, er);
    sb.push_back('{rdata: 32'd0, err: 1'b1});
    xact(0, 1'b1, 16'h0004, 32'h1, rd, er);
    sb.push_back('{rdata: 32'hFFFF_FFFF, err: 1'b0});
    xact(0, 1'b0, 16'h4000, 32'd0, rd, er);
    e = sb.pop_front(); e = sb.pop_front(); e = sb.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err || software_interrupt[0] !== 1'b0) begin
      failures++;
      $display("FAIL err_no_change got=%h/%b sw=%b required=%h/%b sw=0",
               rd, er, software_interrupt[0], e.rdata, e.err);
    end
  endtask

  task automatic test_reset_mid();
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 16'h4000;
    resp_ready[0] = 1'b0;
    #1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'd0 || timer_interrupt[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got v=%b rdata=%h ti=%b required 0/0/0",
               resp_valid[0], resp_rdata[0], timer_interrupt[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    resp_ready[0] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_idle_read();
    test_timer_cmp();
    test_prescaler();
    test_wrap();
    test_msip();
    test_back_to_back();
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
